// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and keeps at most one instruction-memory request in flight.
// It feeds {PC+1, instruction} to IF/ID, catches a fetch that lands during a stall in a one-entry skid, and flushes on redirect.
module if_fetch_unit #(
   parameter int unsigned       ADDR_W   = 12,
   parameter int unsigned       INSTR_W  = 19,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               stall,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               out_valid,
   output logic [ADDR_W-1:0]  out_pc_plus1,
   output logic [INSTR_W-1:0] out_instruction
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_HOLD
   } state_e;

   state_e             state_q, state_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  drain_addr_q, drain_addr_d;
   logic               out_valid_q, out_valid_d;
   logic [ADDR_W-1:0]  out_pc1_q, out_pc1_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [ADDR_W-1:0]  skid_pc1_q, skid_pc1_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0]  pc_inc;
   logic               pending;

   // DRAIN keeps presenting the pre-redirect address while pc already holds the new target
   assign imem_req        = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign imem_addr       = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
   assign out_valid       = out_valid_q;
   assign out_pc_plus1    = out_pc1_q;
   assign out_instruction = out_instr_q;
   assign pc_inc          = pc_q + ADDR_W'(1);
   assign pending         = imem_req && !imem_ack;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      drain_addr_d = drain_addr_q;
      out_valid_d  = out_valid_q;
      out_pc1_d    = out_pc1_q;
      out_instr_d  = out_instr_q;
      skid_pc1_d   = skid_pc1_q;
      skid_instr_d = skid_instr_q;

      if (redirect_valid) begin
         pc_d         = redirect_pc;
         out_valid_d  = 1'b0;
         out_pc1_d    = '0;
         out_instr_d  = '0;
         skid_pc1_d   = '0;
         skid_instr_d = '0;
         if (pending) begin
            state_d      = S_DRAIN;
            drain_addr_d = imem_addr;
         end else begin
            state_d = S_FETCH;
         end
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_FETCH;
            end
            S_FETCH: begin
               if (imem_ack) begin
                  pc_d = pc_inc;
                  if (stall) begin
                     skid_pc1_d   = pc_inc;
                     skid_instr_d = imem_rdata;
                     state_d      = S_HOLD;
                  end else begin
                     out_valid_d = 1'b1;
                     out_pc1_d   = pc_inc;
                     out_instr_d = imem_rdata;
                  end
               end else if (!stall) begin
                  out_valid_d = 1'b0;
                  out_pc1_d   = '0;
                  out_instr_d = '0;
               end
            end
            S_DRAIN: begin
               if (imem_ack) begin
                  state_d = S_FETCH;
               end
            end
            S_HOLD: begin
               if (!stall) begin
                  out_valid_d  = 1'b1;
                  out_pc1_d    = skid_pc1_q;
                  out_instr_d  = skid_instr_q;
                  skid_pc1_d   = '0;
                  skid_instr_d = '0;
                  state_d      = S_FETCH;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         drain_addr_q <= '0;
         out_valid_q  <= 1'b0;
         out_pc1_q    <= '0;
         out_instr_q  <= '0;
         skid_pc1_q   <= '0;
         skid_instr_q <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         drain_addr_q <= drain_addr_d;
         out_valid_q  <= out_valid_d;
         out_pc1_q    <= out_pc1_d;
         out_instr_q  <= out_instr_d;
         skid_pc1_q   <= skid_pc1_d;
         skid_instr_q <= skid_instr_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal expectations followed by a randomized run
// compared every cycle against a request/skid/flush model of the fetch stage.
module tb_if_fetch_unit;

   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned INSTR_W = 19;
   localparam logic [11:0] RESET_PC = 12'h000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [11:0] imem_addr;
   logic        imem_ack;
   logic [18:0] imem_rdata;
   logic        stall;
   logic        redirect_valid;
   logic [11:0] redirect_pc;
   logic        out_valid;
   logic [11:0] out_pc_plus1;
   logic [18:0] out_instruction;

   int compared   = 0;
   int mismatched = 0;
   int memLat     = 1;
   int memAge     = 0;

   // Model state: an open request (possibly one whose data must be discarded),
   // a full/empty skid entry, the sequential fetch pointer and the IF/ID output word.
   logic        chkEn = 1'b0;
   logic        mIdle, mReqOpen, mDiscard, mSkidFull, mOutV;
   logic [11:0] mPc, mReqAddr, mSkidPc1, mOutPc1;
   logic [18:0] mSkidInstr, mOutInstr;

   logic        pValid = 1'b0;
   logic        pReq, pAck, pRst;
   logic [11:0] pAddr;

   if_fetch_unit #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .RESET_PC(RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_pc_plus1   (out_pc_plus1),
      .out_instruction(out_instruction)
   );

   always #5 clk = ~clk;

   function automatic logic [18:0] memData(input logic [11:0] a);
      return 19'(a) * 19'd3;
   endfunction

   // Reference model advanced on every active edge from the same inputs the DUT samples
   always @(posedge clk) begin : modelProc
      logic        nIdle, nOpen, nDisc, nSkid, nV;
      logic [11:0] nPc, nAddr, nSkidPc1, nPc1;
      logic [18:0] nSkidInstr, nInstr;
      nIdle = mIdle; nOpen = mReqOpen; nDisc = mDiscard; nSkid = mSkidFull; nV = mOutV;
      nPc = mPc; nAddr = mReqAddr; nSkidPc1 = mSkidPc1; nPc1 = mOutPc1;
      nSkidInstr = mSkidInstr; nInstr = mOutInstr;
      if (!rst) begin
         nIdle = 1'b1; nOpen = 1'b0; nDisc = 1'b0; nSkid = 1'b0;
         nPc = RESET_PC; nAddr = RESET_PC;
         nV = 1'b0; nPc1 = 12'h000; nInstr = 19'h0;
         nSkidPc1 = 12'h000; nSkidInstr = 19'h0;
      end else if (redirect_valid) begin
         nV = 1'b0; nPc1 = 12'h000; nInstr = 19'h0;
         nSkid = 1'b0; nIdle = 1'b0; nPc = redirect_pc;
         if (mReqOpen && !imem_ack) begin
            nDisc = 1'b1;
         end else begin
            nOpen = 1'b1; nAddr = redirect_pc; nDisc = 1'b0;
         end
      end else if (mIdle) begin
         nIdle = 1'b0; nOpen = 1'b1; nAddr = mPc;
      end else if (mSkidFull) begin
         if (!stall) begin
            nV = 1'b1; nPc1 = mSkidPc1; nInstr = mSkidInstr;
            nSkid = 1'b0; nOpen = 1'b1; nAddr = mPc;
         end
      end else if (mReqOpen) begin
         if (imem_ack) begin
            if (mDiscard) begin
               nDisc = 1'b0; nAddr = mPc;
            end else begin
               nPc = mReqAddr + 12'd1;
               if (stall) begin
                  nSkid = 1'b1; nSkidPc1 = nPc; nSkidInstr = imem_rdata; nOpen = 1'b0;
               end else begin
                  nV = 1'b1; nPc1 = nPc; nInstr = imem_rdata; nAddr = nPc;
               end
            end
         end else if (!mDiscard && !stall) begin
            nV = 1'b0; nPc1 = 12'h000; nInstr = 19'h0;
         end
      end
      mIdle <= nIdle; mReqOpen <= nOpen; mDiscard <= nDisc; mSkidFull <= nSkid; mOutV <= nV;
      mPc <= nPc; mReqAddr <= nAddr; mSkidPc1 <= nSkidPc1; mOutPc1 <= nPc1;
      mSkidInstr <= nSkidInstr; mOutInstr <= nInstr;
      if (!rst) chkEn <= 1'b1;
   end

   // Single compare process: model agreement, fetched-word content and request stability
   always @(negedge clk) begin
      if (chkEn) begin
         compared++;
         if (imem_req !== mReqOpen || (mReqOpen && imem_addr !== mReqAddr) ||
             out_valid !== mOutV || out_pc_plus1 !== mOutPc1 || out_instruction !== mOutInstr) begin
            mismatched++;
            $display("[TB] FAIL model t=%0t: got req=%b addr=%h v=%b pc1=%h ins=%h, expected req=%b addr=%h v=%b pc1=%h ins=%h",
                     $time, imem_req, imem_addr, out_valid, out_pc_plus1, out_instruction,
                     mReqOpen, mReqAddr, mOutV, mOutPc1, mOutInstr);
         end
         if (out_valid === 1'b1) begin
            compared++;
            if (out_instruction !== memData(out_pc_plus1 - 12'd1)) begin
               mismatched++;
               $display("[TB] FAIL content t=%0t: got ins=%h for pc1=%h, expected %h",
                        $time, out_instruction, out_pc_plus1, memData(out_pc_plus1 - 12'd1));
            end
         end
         if (pValid && pReq && !pAck && pRst) begin
            compared++;
            if (imem_req !== 1'b1 || imem_addr !== pAddr) begin
               mismatched++;
               $display("[TB] FAIL reqhold t=%0t: got req=%b addr=%h, expected req=1 addr=%h",
                        $time, imem_req, imem_addr, pAddr);
            end
         end
         pValid = 1'b1;
         pReq   = imem_req;
         pAddr  = imem_addr;
         pAck   = imem_ack;
         pRst   = rst;
      end
   end

   // Waits for the next edge, then drives the inputs for the following edge and plays memory
   task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                input logic [11:0] rpc, input logic stale);
      @(posedge clk);
      #1;
      rst            = r;
      stall          = s;
      redirect_valid = rd;
      redirect_pc    = rpc;
      if (stale) begin
         imem_ack   = 1'b1;
         imem_rdata = 19'h5A5A5;
         memAge     = 0;
      end else if (imem_req === 1'b1) begin
         if (memAge + 1 >= memLat) begin
            imem_ack   = 1'b1;
            imem_rdata = memData(imem_addr);
            memAge     = 0;
         end else begin
            imem_ack = 1'b0;
            memAge++;
         end
      end else begin
         imem_ack = 1'b0;
         memAge   = 0;
      end
   endtask

   task automatic tick(input logic s);
      applyStimulus(1'b1, s, 1'b0, 12'h000, 1'b0);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   initial begin
      int pulses;
      logic r, s, rd, stl;
      logic [11:0] rpc;
      rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 12'h000;
      imem_ack = 1'b0; imem_rdata = 19'h0;

      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b1);
      checkOutput("reset req", 32'(imem_req), 32'h0);
      checkOutput("reset valid", 32'(out_valid), 32'h0);
      checkOutput("reset pc1", 32'(out_pc_plus1), 32'h0);
      checkOutput("reset instr", 32'(out_instruction), 32'h0);

      // 1-cycle memory, then a 4-cycle stall that catches the fetch of addr 5
      tick(1'b0);
      checkOutput("first req", 32'(imem_req), 32'h1);
      checkOutput("first addr", 32'(imem_addr), 32'(RESET_PC));
      checkOutput("stale ack ignored", 32'(out_valid), 32'h0);
      tick(1'b0);
      checkOutput("seq0 valid", 32'(out_valid), 32'h1);
      checkOutput("seq0 pc1", 32'(out_pc_plus1), 32'h001);
      checkOutput("seq0 instr", 32'(out_instruction), 32'h0);
      checkOutput("seq0 next addr", 32'(imem_addr), 32'h001);
      tick(1'b0);
      checkOutput("seq1 pc1", 32'(out_pc_plus1), 32'h002);
      checkOutput("seq1 instr", 32'(out_instruction), 32'h003);
      checkOutput("seq1 next addr", 32'(imem_addr), 32'h002);
      tick(1'b0);
      checkOutput("seq2 pc1", 32'(out_pc_plus1), 32'h003);
      checkOutput("seq2 instr", 32'(out_instruction), 32'h006);
      tick(1'b0);
      tick(1'b1);
      checkOutput("pre-stall pc1", 32'(out_pc_plus1), 32'h005);
      checkOutput("pre-stall addr", 32'(imem_addr), 32'h005);
      tick(1'b1);
      checkOutput("hold req", 32'(imem_req), 32'h0);
      checkOutput("hold pc1", 32'(out_pc_plus1), 32'h005);
      checkOutput("hold instr", 32'(out_instruction), 32'h00C);
      tick(1'b1);
      tick(1'b1);
      tick(1'b0);
      checkOutput("hold end req", 32'(imem_req), 32'h0);
      tick(1'b0);
      checkOutput("release pc1", 32'(out_pc_plus1), 32'h006);
      checkOutput("release instr", 32'(out_instruction), 32'h00F);
      checkOutput("release addr", 32'(imem_addr), 32'h006);
      tick(1'b0);
      checkOutput("after release pc1", 32'(out_pc_plus1), 32'h007);
      checkOutput("after release instr", 32'(out_instruction), 32'h012);

      // Reset while in HOLD
      tick(1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 12'h000, 1'b0);
      checkOutput("hold before reset", 32'(imem_req), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
      checkOutput("hold reset req", 32'(imem_req), 32'h0);
      checkOutput("hold reset valid", 32'(out_valid), 32'h0);
      checkOutput("hold reset pc1", 32'(out_pc_plus1), 32'h0);
      checkOutput("hold reset instr", 32'(out_instruction), 32'h0);

      // 3-cycle memory: one valid word every third cycle
      memLat = 3;
      tick(1'b0);
      checkOutput("lat3 first addr", 32'(imem_addr), 32'(RESET_PC));
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         tick(1'b0);
         pulses += int'(out_valid);
      end
      checkOutput("lat3 pulses", 32'(pulses), 32'd3);

      // Reset mid-request, then redirect to 0x040 while 0x010 is pending
      applyStimulus(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 12'h010, 1'b0);
      checkOutput("req reset req", 32'(imem_req), 32'h0);
      checkOutput("req reset valid", 32'(out_valid), 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 12'h040, 1'b0);
      checkOutput("redir1 addr", 32'(imem_addr), 32'h010);
      tick(1'b0);
      checkOutput("drain addr", 32'(imem_addr), 32'h010);
      checkOutput("drain bubble", 32'(out_valid), 32'h0);
      tick(1'b0);
      checkOutput("drain addr held", 32'(imem_addr), 32'h010);
      tick(1'b0);
      checkOutput("redir2 addr", 32'(imem_addr), 32'h040);
      checkOutput("drained data hidden", 32'(out_valid), 32'h0);
      tick(1'b0);
      tick(1'b0);
      tick(1'b0);
      checkOutput("redir2 pc1", 32'(out_pc_plus1), 32'h041);
      checkOutput("redir2 instr", 32'(out_instruction), 32'h0C0);

      // PC wrap at all-ones
      memLat = 1;
      applyStimulus(1'b1, 1'b0, 1'b1, 12'hFFF, 1'b0);
      tick(1'b0);
      checkOutput("wrap addr", 32'(imem_addr), 32'hFFF);
      tick(1'b0);
      checkOutput("wrap valid", 32'(out_valid), 32'h1);
      checkOutput("wrap pc1", 32'(out_pc_plus1), 32'h000);
      checkOutput("wrap instr", 32'(out_instruction), 32'h2FFD);
      checkOutput("wrap next addr", 32'(imem_addr), 32'h000);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 49) == 0) memLat = int'($urandom_range(1, 4));
         r  = ($urandom_range(0, 99) != 0);
         s  = ($urandom_range(0, 3) == 0);
         rd = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       rpc = 12'hFFF;
            1:       rpc = 12'hFFE;
            default: rpc = 12'($urandom);
         endcase
         stl = r & ~rst;
         applyStimulus(r, s, rd, rpc, stl);
      end
      tick(1'b0);
      tick(1'b0);
      @(posedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
